// File: rtl/arb_pkg.sv
// ============================================================
// arb_pkg : shared types, defaults and mask helper for the arbiter
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

package arb_pkg;

  localparam int DEF_N        = 8;
  localparam int DEF_MAX_HOLD = 16;
  localparam int MAXN         = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Mask of all indices strictly below idx; callers truncate to their own width.
  function automatic logic [MAXN-1:0] mask_below(input int unsigned idx);
    return (MAXN'(1) << idx) - MAXN'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/msb_find.sv
// ============================================================
// msb_find : index of the highest set bit of vec, plus any-set flag
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module msb_find #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  // Ascending scan: the last set bit seen overwrites earlier ones.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = IDXW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_msb_arbiter.sv
// ============================================================
// rr_msb_arbiter : downward-rotating round-robin arbiter with hold timeout
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module rr_msb_arbiter
  import arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int IDXW     = $clog2(N)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  localparam int HW = $clog2(MAX_HOLD);

  state_t          state;
  logic [IDXW-1:0] last_idx;
  logic [HW-1:0]   hold_cnt;

  logic [N-1:0]    mask_lo;
  logic [N-1:0]    masked;
  logic [IDXW-1:0] masked_idx;
  logic [IDXW-1:0] req_idx;
  logic            masked_any;
  logic            req_any;
  logic [IDXW-1:0] winner;
  logic            release_now;

  assign mask_lo = N'(mask_below(32'(last_idx)));
  assign masked  = req & mask_lo;

  msb_find #(.N(N), .IDXW(IDXW)) u_find_masked (
    .vec (masked),
    .idx (masked_idx),
    .any (masked_any)
  );

  msb_find #(.N(N), .IDXW(IDXW)) u_find_req (
    .vec (req),
    .idx (req_idx),
    .any (req_any)
  );

  // Prefer requesters below the last winner; wrap to the top otherwise.
  assign winner = masked_any ? masked_idx : req_idx;

  assign release_now = done || !req[grant_idx] || (hold_cnt == HW'(MAX_HOLD - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      last_idx    <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            state       <= BUSY;
            grant       <= N'(1) << winner;
            grant_idx   <= winner;
            grant_valid <= 1'b1;
            last_idx    <= winner;
            hold_cnt    <= '0;
          end
        end
        BUSY: begin
          // grant_idx is left untouched on release.
          if (release_now) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
          hold_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_msb_arbiter.sv
// ============================================================
// tb_rr_msb_arbiter : directed scoreboard bench for rr_msb_arbiter
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module tb_rr_msb_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 16;
  localparam int IDXW     = 3;

  logic            clock = 1'b0;
  logic            resetn;
  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_valid;

  int n_asserts = 0;
  int n_fail    = 0;
  int exp_q[$];

  rr_msb_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDXW(IDXW)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the next expected owner and compare the full grant interface.
  task automatic expect_grant(input string tag);
    int           e;
    logic [N-1:0] oh;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e  = exp_q.pop_front();
      oh = N'(1) << e;
      chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
      chk({tag, "_idx"},   32'(grant_idx),   32'(e));
      chk({tag, "_grant"}, 32'(grant),       32'(oh));
    end
  endtask

  // Count consecutive grant_valid cycles starting from the current one.
  task automatic count_hold(input string tag, input int exp_len);
    int cnt;
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (grant_valid) cnt++;
      else break;
    end
    chk(tag, 32'(cnt), 32'(exp_len));
  endtask

  task automatic release_by_done_and_regrant(input string tag);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk({tag, "_dead"}, 32'(grant_valid), 32'd0);
    tick();
    expect_grant(tag);
  endtask

  initial begin
    resetn = 1'b0;
    req    = '0;
    done   = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(grant),       32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_idx",   32'(grant_idx),   32'd0);
    resetn = 1'b1;

    // Rotation over a sparse request pattern.
    req = 8'b1010_0100;
    exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(7);
    tick();
    expect_grant("rot0");
    for (int k = 0; k < 3; k++) release_by_done_and_regrant("rot");
    req = '0;
    tick();
    chk("rot_drop_valid", 32'(grant_valid), 32'd0);
    chk("rot_keep_idx",   32'(grant_idx),   32'd7);
    tick();
    chk("rot_idle_valid", 32'(grant_valid), 32'd0);

    // Sole requester never releasing: forced timeout and regrant.
    req = 8'b0000_1000;
    exp_q.push_back(3);
    tick();
    expect_grant("hold0");
    count_hold("hold_len0", MAX_HOLD);
    exp_q.push_back(3);
    tick();
    expect_grant("hold1");
    count_hold("hold_len1", MAX_HOLD);
    req = '0;
    tick();
    tick();
    chk("hold_idle", 32'(grant_valid), 32'd0);

    // Reach owner 6, then drop its request.
    req = 8'b1000_0000;
    exp_q.push_back(7);
    tick();
    expect_grant("pre7");
    req = 8'b0100_0001;
    tick();
    chk("pre7_dead", 32'(grant_valid), 32'd0);
    exp_q.push_back(6);
    tick();
    expect_grant("own6");
    req = 8'b0000_0001;
    tick();
    chk("own6_drop_valid", 32'(grant_valid), 32'd0);
    chk("own6_drop_grant", 32'(grant),       32'd0);
    exp_q.push_back(0);
    tick();
    expect_grant("own0");
    req = '0;
    tick();

    // done while idle is ignored.
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("idle_done0", 32'(grant_valid), 32'd0);
    tick();
    chk("idle_done1", 32'(grant_valid), 32'd0);

    // done coincident with the owner dropping its request.
    req = 8'b0001_0010;
    exp_q.push_back(4);
    tick();
    expect_grant("coin4");
    tick();
    req  = 8'b0000_0010;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("coin_dead", 32'(grant_valid), 32'd0);
    exp_q.push_back(1);
    tick();
    expect_grant("coin1");

    // Asynchronous reset in the middle of a grant to index 4.
    req = 8'b0001_0000;
    tick();
    chk("pre4_dead", 32'(grant_valid), 32'd0);
    exp_q.push_back(4);
    tick();
    expect_grant("mid4");
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(grant_valid), 32'd0);
    chk("arst_grant", 32'(grant),       32'd0);
    @(negedge clock);
    resetn = 1'b1;
    req    = 8'hFF;
    exp_q.push_back(7);
    tick();
    expect_grant("post_rst");

    // Full fairness sweep.
    for (int k = 6; k >= 0; k--) exp_q.push_back(k);
    exp_q.push_back(7);
    for (int k = 0; k < 8; k++) release_by_done_and_regrant("fair");
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/rr_msb_arbiter.md
Name: rr_msb_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters.
- Winner selection reuses the MSB-find datapath: the highest set index wins, with priority rotating downward after each grant.
- Sits between requester ports and the shared resource.
- Registered grant, hold-until-release ownership, forced preemption after MAX_HOLD cycles.

Parameters:
- N, 8, number of requesters (power of two, >=2).
- IDXW, $clog2(N) = 3, index width.
- MAX_HOLD, 16, max consecutive BUSY cycles per grant (>=2).

Ports:
- clock  input  1  clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i held high while requester i wants the resource.
- done  input  1  single-cycle release pulse from the current owner.
- grant  output  N  one-hot grant, registered.
- grant_idx  output  IDXW  index of current owner; valid only when grant_valid.
- grant_valid  output  1  high while any grant is active.

Behaviour:
- Reset (async, resetn low): grant=0, grant_idx=0, grant_valid=0, state=IDLE, last_idx=0, hold_cnt=0. Takes effect immediately, including mid-grant.
- States: IDLE, BUSY (2-state enum).
- Winner computation (combinational):
  - masked = req & ((1<<last_idx)-1), i.e. indices strictly below last_idx.
  - If masked != 0, winner = MSB index of masked; else winner = MSB index of req.
  - Priority order after granting k: k-1 down to 0, then N-1 down to k.
  - With last_idx=0 after reset, masked is empty, so the highest set bit of req wins.
- IDLE:
  - If req != 0 at a clock edge: next cycle state=BUSY, grant=1<<winner, grant_idx=winner, grant_valid=1, last_idx=winner, hold_cnt=0.
  - Latency is 1 cycle from req sampled to grant visible.
  - If req == 0: remain IDLE. done is ignored in IDLE.
- BUSY: hold_cnt increments each cycle. Release occurs at the edge where any of these holds:
  - (a) done=1
  - (b) req[grant_idx]=0
  - (c) hold_cnt == MAX_HOLD-1
- On release:
  - Next cycle grant=0, grant_valid=0, state=IDLE, hold_cnt=0.
  - grant_idx keeps its last value.
  - This forces one mandatory dead cycle between consecutive grants.
- Simultaneous release conditions behave the same as a single one.
- Owner duration:
  - A preempted owner still requesting drops to lowest priority via last_idx.
  - If it is the only requester, it is regranted after the dead cycle.
- Changes to non-owner req bits during BUSY never affect the current grant.
- hold_cnt width is $clog2(MAX_HOLD); no wrap occurs because release fires at MAX_HOLD-1.
- Maximum BUSY length is exactly MAX_HOLD cycles of grant_valid=1.
- Invariants: grant is always one-hot or zero; grant_valid == |grant; grant == 1<<grant_idx when valid.

Decomposition:
- Package arb_pkg:
  - state enum (IDLE, BUSY)
  - default N and MAX_HOLD constants
  - function mask_below(idx) returning the lower-index mask
- Sub-module msb_find:
  - Combinational, parameter N.
  - Inputs: vec[N]. Outputs: idx[IDXW], any.
  - Scans 0..N-1 so the last set bit wins.
  - Instantiated twice: once on masked, once on req.
- Top module holds the FSM, hold counter, last_idx and grant registers.

Test Plan:
- Reset, req=8'b1010_0100, done pulsed 2 cycles after each grant -> grant_idx sequence 7,5,2,7, with grant_valid low for exactly 1 cycle between grants; first grant 1 cycle after req sampled.
- req=8'b0000_1000 held, done never asserted, MAX_HOLD=16 -> grant_idx=3 valid 16 cycles, 1 dead cycle, regrant 3; repeats.
- Owner index 6 active, req=8'b0100_0001, req[6] deasserted -> grant=0 next cycle, then grant_idx=0.
- done pulsed while IDLE with req=0 -> no grant, no state change. done coincident with owner req drop -> single release, one dead cycle.
- Reset asserted mid-grant (grant_idx=4) -> grant=0 and grant_valid=0 asynchronously. After release with req=8'hFF -> grant_idx=7 first (last_idx reset to 0).
- All-requester fairness: req=8'hFF held, done each grant -> indices 7,6,5,4,3,2,1,0,7; each requester granted once per 8 grants.
